// File: rtl/sargantana_icache_pkg.sv
// Shared constants, types and helpers for the
// registered instruction-cache tag checker.
package sargantana_icache_pkg;

    localparam int N_WAY_DEF   = 4;
    localparam int TAG_W_DEF   = 20;
    localparam int LINE_W_DEF  = 256;
    localparam int FETCH_W_DEF = 128;
    localparam int CNT_W_DEF   = 32;

    typedef struct packed {
        logic                 hit;
        logic [N_WAY_DEF-1:0] way;
        logic                 multihit;
    } chk_res_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } ostate_e;

    function automatic int chunk_idx_w(input int chunks);
        return (chunks > 1) ? $clog2(chunks) : 1;
    endfunction

endpackage

// File: rtl/sargantana_icache_way_prio.sv
// Lowest-index priority encoder over way hits,
// flagging when more than one way hits.
module sargantana_icache_way_prio #(
    parameter int N_WAY = 4
) (
    input  logic [N_WAY-1:0] hit_vec_i,
    output logic [N_WAY-1:0] onehot_o,
    output logic             hit_o,
    output logic             multihit_o
);

    always_comb begin
        onehot_o   = '0;
        hit_o      = 1'b0;
        multihit_o = 1'b0;
        for (int i = 0; i < N_WAY; i++) begin
            if (hit_vec_i[i]) begin
                if (hit_o) begin
                    multihit_o = 1'b1;
                end else begin
                    onehot_o[i] = 1'b1;
                end
                hit_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sargantana_icache_checker_pipe.sv
// Tag compare, chunk select and a one-entry
// valid/ready response slot with hit/miss counters.
module sargantana_icache_checker_pipe
    import sargantana_icache_pkg::*;
#(
    parameter int N_WAY   = N_WAY_DEF,
    parameter int TAG_W   = TAG_W_DEF,
    parameter int LINE_W  = LINE_W_DEF,
    parameter int FETCH_W = FETCH_W_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    localparam int CHUNKS = LINE_W / FETCH_W,
    localparam int IDX_W  = chunk_idx_w(CHUNKS)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      flush_i,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [TAG_W-1:0]          cline_tag_i,
    input  logic [N_WAY-1:0]          way_valid_bits_i,
    input  logic [N_WAY*TAG_W-1:0]    read_tags_i,
    input  logic [N_WAY*LINE_W-1:0]   data_rd_i,
    input  logic [IDX_W-1:0]          fetch_idx_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic                      rsp_hit_o,
    output logic [N_WAY-1:0]          rsp_way_o,
    output logic                      rsp_multihit_o,
    output logic [FETCH_W-1:0]        rsp_data_o,
    input  logic                      cnt_clear_i,
    output logic [CNT_W-1:0]          hit_cnt_o,
    output logic [CNT_W-1:0]          miss_cnt_o
);

    logic [N_WAY-1:0]   hit_vec;
    logic [N_WAY-1:0]   sel_oh;
    logic               any_hit;
    logic               multi;
    logic [IDX_W-1:0]   fidx;
    logic [LINE_W-1:0]  line;
    logic [FETCH_W-1:0] chunk;

    ostate_e            state_q, state_d;
    logic               hit_q, hit_d;
    logic [N_WAY-1:0]   way_q, way_d;
    logic               multi_q, multi_d;
    logic [FETCH_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;

    logic accept;
    logic consume;

    for (genvar i = 0; i < N_WAY; i++) begin : g_cmp
        assign hit_vec[i] = way_valid_bits_i[i] &
            (read_tags_i[i*TAG_W +: TAG_W] == cline_tag_i);
    end

    sargantana_icache_way_prio #(
        .N_WAY (N_WAY)
    ) u_prio (
        .hit_vec_i  (hit_vec),
        .onehot_o   (sel_oh),
        .hit_o      (any_hit),
        .multihit_o (multi)
    );

    if (CHUNKS > 1) begin : g_idx
        assign fidx = fetch_idx_i;
    end else begin : g_noidx
        assign fidx = '0;
    end

    // A miss leaves line at zero, so the chunk is zero too.
    always_comb begin
        line = '0;
        for (int i = 0; i < N_WAY; i++) begin
            if (sel_oh[i]) begin
                line = data_rd_i[i*LINE_W +: LINE_W];
            end
        end
        chunk = line[fidx*FETCH_W +: FETCH_W];
    end

    always_comb begin
        rsp_valid_o = 1'b0;
        unique case (state_q)
            ST_EMPTY: rsp_valid_o = 1'b0;
            ST_FULL:  rsp_valid_o = 1'b1;
            default:  rsp_valid_o = 1'b0;
        endcase
        req_ready_o = ~rsp_valid_o | rsp_ready_i;
    end

    assign accept  = req_valid_i & req_ready_o & ~flush_i;
    assign consume = rsp_valid_o & rsp_ready_i & ~flush_i;

    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = ST_EMPTY;
        end else if (accept) begin
            state_d = ST_FULL;
        end else if (consume) begin
            state_d = ST_EMPTY;
        end
    end

    always_comb begin
        hit_d   = hit_q;
        way_d   = way_q;
        multi_d = multi_q;
        data_d  = data_q;
        if (accept) begin
            hit_d   = any_hit;
            way_d   = sel_oh;
            multi_d = multi;
            data_d  = chunk;
        end
    end

    // Clear wins over a same-cycle increment; both saturate.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (cnt_clear_i) begin
            hit_cnt_d  = '0;
            miss_cnt_d = '0;
        end else if (consume) begin
            if (hit_q) begin
                if (~&hit_cnt_q) hit_cnt_d = hit_cnt_q + CNT_W'(1);
            end else begin
                if (~&miss_cnt_q) miss_cnt_d = miss_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_EMPTY;
            hit_q      <= 1'b0;
            way_q      <= '0;
            multi_q    <= 1'b0;
            data_q     <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hit_q      <= hit_d;
            way_q      <= way_d;
            multi_q    <= multi_d;
            data_q     <= data_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign rsp_hit_o      = hit_q;
    assign rsp_way_o      = way_q;
    assign rsp_multihit_o = multi_q;
    assign rsp_data_o     = data_q;
    assign hit_cnt_o      = hit_cnt_q;
    assign miss_cnt_o     = miss_cnt_q;

endmodule

// File: tb/tb_sargantana_icache_checker_pipe.sv
// Scoreboard bench for the registered tag checker:
// directed cases from the plan plus random traffic.
module tb_sargantana_icache_checker_pipe;

    localparam int NW = 4;
    localparam int TW = 20;
    localparam int LW = 256;
    localparam int FW = 128;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct packed {
        logic          hit;
        logic [NW-1:0] way;
        logic          multi;
        logic [FW-1:0] data;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush_i;
    logic             req_valid_i;
    logic             req_ready_o;
    logic [TW-1:0]    cline_tag_i;
    logic [NW-1:0]    way_valid_bits_i;
    logic [NW*TW-1:0] read_tags_i;
    logic [NW*LW-1:0] data_rd_i;
    logic             fetch_idx_i;
    logic             rsp_valid_o;
    logic             rsp_ready_i;
    logic             rsp_hit_o;
    logic [NW-1:0]    rsp_way_o;
    logic             rsp_multihit_o;
    logic [FW-1:0]    rsp_data_o;
    logic             cnt_clear_i;
    logic [CW-1:0]    hit_cnt_o;
    logic [CW-1:0]    miss_cnt_o;

    int   checks = 0;
    int   failures = 0;
    bit   mon_on = 1'b0;
    exp_t q[$];
    int   hc = 0;
    int   mc = 0;

    sargantana_icache_checker_pipe #(
        .N_WAY   (NW),
        .TAG_W   (TW),
        .LINE_W  (LW),
        .FETCH_W (FW),
        .CNT_W   (CW)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .flush_i          (flush_i),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .cline_tag_i      (cline_tag_i),
        .way_valid_bits_i (way_valid_bits_i),
        .read_tags_i      (read_tags_i),
        .data_rd_i        (data_rd_i),
        .fetch_idx_i      (fetch_idx_i),
        .rsp_valid_o      (rsp_valid_o),
        .rsp_ready_i      (rsp_ready_i),
        .rsp_hit_o        (rsp_hit_o),
        .rsp_way_o        (rsp_way_o),
        .rsp_multihit_o   (rsp_multihit_o),
        .rsp_data_o       (rsp_data_o),
        .cnt_clear_i      (cnt_clear_i),
        .hit_cnt_o        (hit_cnt_o),
        .miss_cnt_o       (miss_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm,
                       input logic [FW-1:0] act,
                       input logic [FW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    function automatic logic [NW*TW-1:0] mk(
        input logic [TW-1:0] t0, input logic [TW-1:0] t1,
        input logic [TW-1:0] t2, input logic [TW-1:0] t3);
        return {t3, t2, t1, t0};
    endfunction

    // Reference: first matching valid way wins; count all matches.
    function automatic exp_t model(
        input logic [TW-1:0] tag, input logic [NW-1:0] vb,
        input logic [NW*TW-1:0] tags, input logic [NW*LW-1:0] d,
        input logic idx);
        exp_t e;
        int   n;
        logic [LW-1:0] ln;
        e = '0;
        n = 0;
        for (int w = 0; w < NW; w++) begin
            if (vb[w] && tags[w*TW +: TW] == tag) begin
                n++;
                if (!e.hit) begin
                    e.hit  = 1'b1;
                    e.way  = NW'(1) << w;
                    ln     = d[w*LW +: LW];
                    e.data = idx ? ln[255:128] : ln[127:0];
                end
            end
        end
        e.multi = (n > 1);
        return e;
    endfunction

    task automatic cyc(input logic v, input logic fl,
                       input logic rdy, input logic clr,
                       input logic [TW-1:0] tag,
                       input logic [NW-1:0] vb,
                       input logic [NW*TW-1:0] tags,
                       input logic idx);
        logic [NW*LW-1:0] d;
        exp_t e;
        bit   acc;
        for (int k = 0; k < NW*LW/32; k++) d[k*32 +: 32] = $urandom;
        req_valid_i      = v;
        flush_i          = fl;
        rsp_ready_i      = rdy;
        cnt_clear_i      = clr;
        cline_tag_i      = tag;
        way_valid_bits_i = vb;
        read_tags_i      = tags;
        data_rd_i        = d;
        fetch_idx_i      = idx;
        e   = model(tag, vb, tags, d, idx);
        acc = v && (q.size() == 0 || rdy) && !fl;
        @(posedge clk);
        if (fl) q.delete();
        else if (acc) q.push_back(e);
        #1;
    endtask

    task automatic idle(input logic rdy);
        cyc(1'b0, 1'b0, rdy, 1'b0, '0, '0, '0, 1'b0);
    endtask

    always @(negedge clk) begin
        bit   full;
        bit   cons;
        exp_t e;
        if (mon_on) begin
            full = (q.size() != 0);
            cons = full && rsp_ready_i && !flush_i;
            chk("req_ready", FW'(req_ready_o), FW'(!full || rsp_ready_i));
            chk("rsp_valid", FW'(rsp_valid_o), FW'(full));
            chk("hit_cnt", FW'(hit_cnt_o), FW'(hc));
            chk("miss_cnt", FW'(miss_cnt_o), FW'(mc));
            e = '0;
            if (full) begin
                e = cons ? q.pop_front() : q[0];
                chk("rsp_hit", FW'(rsp_hit_o), FW'(e.hit));
                chk("rsp_way", FW'(rsp_way_o), FW'(e.way));
                chk("rsp_multi", FW'(rsp_multihit_o), FW'(e.multi));
                chk("rsp_data", rsp_data_o, e.data);
            end
            if (cnt_clear_i) begin
                hc = 0;
                mc = 0;
            end else if (cons) begin
                if (e.hit) hc = (hc < CMAX) ? hc + 1 : CMAX;
                else       mc = (mc < CMAX) ? mc + 1 : CMAX;
            end
        end
    end

    initial begin
        logic [TW-1:0] t;
        logic [TW-1:0] pool [4];
        rst = 1'b1;
        flush_i = 0; req_valid_i = 0; rsp_ready_i = 0;
        cnt_clear_i = 0; cline_tag_i = '0;
        way_valid_bits_i = '0; read_tags_i = '0;
        data_rd_i = '0; fetch_idx_i = 0;
        #3;
        chk("rst_valid", FW'(rsp_valid_o), '0);
        chk("rst_ready", FW'(req_ready_o), FW'(1));
        chk("rst_hit", FW'(rsp_hit_o), '0);
        chk("rst_way", FW'(rsp_way_o), '0);
        chk("rst_multi", FW'(rsp_multihit_o), '0);
        chk("rst_data", rsp_data_o, '0);
        chk("rst_hcnt", FW'(hit_cnt_o), '0);
        chk("rst_mcnt", FW'(miss_cnt_o), '0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        mon_on = 1'b1;

        t = 20'h12345;
        // Single hit in way 2, upper chunk.
        cyc(1, 0, 1, 0, t, 4'b1111, mk(20'h1, 20'h2, t, 20'h3), 1);
        idle(1);
        // Matching tags but nothing valid: miss.
        cyc(1, 0, 1, 0, t, 4'b0000, mk(t, t, t, t), 0);
        idle(1);
        // Ways 1 and 3 match: lowest wins, multihit flagged.
        cyc(1, 0, 1, 0, t, 4'b1111, mk(20'h5, t, 20'h7, t), 0);
        idle(1);
        // Back-pressure then back-to-back drain.
        cyc(1, 0, 1, 0, t, 4'b0100, mk(0, 0, t, 0), 0);
        for (int i = 0; i < 5; i++)
            cyc(1, 0, 0, 0, t, 4'b0001, mk(t, 0, 0, 0), 1);
        for (int i = 0; i < 4; i++)
            cyc(1, 0, 1, 0, t, 4'(1 << i), mk(t, t, t, t), 1'(i));
        idle(1);
        idle(1);
        // Flush while full with a request pending.
        cyc(1, 0, 0, 0, t, 4'b1000, mk(0, 0, 0, t), 0);
        cyc(1, 1, 0, 0, t, 4'b1000, mk(0, 0, 0, t), 1);
        idle(1);
        idle(1);
        // Saturation of the hit counter, then clear vs consume.
        idle(1);
        cyc(0, 0, 1, 1, '0, '0, '0, 0);
        for (int i = 0; i < 17; i++)
            cyc(1, 0, 1, 0, t, 4'b0010, mk(0, t, 0, 0), 0);
        idle(1);
        idle(1);
        cyc(1, 0, 1, 0, t, 4'b0010, mk(0, t, 0, 0), 0);
        cyc(0, 0, 1, 1, '0, '0, '0, 0);
        idle(1);

        pool[0] = 20'hABCDE; pool[1] = 20'h00F0F;
        pool[2] = 20'h12345; pool[3] = 20'hFFFFF;
        for (int i = 0; i < 400; i++) begin
            logic [NW*TW-1:0] tg;
            for (int w = 0; w < NW; w++)
                tg[w*TW +: TW] = pool[$urandom_range(0, 3)];
            cyc(1'($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 15) == 0),
                1'($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 31) == 0),
                pool[$urandom_range(0, 3)],
                4'($urandom), tg, 1'($urandom));
        end

        // Asynchronous reset while holding a response.
        cyc(1, 0, 0, 0, t, 4'b0001, mk(t, 0, 0, 0), 0);
        mon_on = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        chk("arst_valid", FW'(rsp_valid_o), '0);
        chk("arst_ready", FW'(req_ready_o), FW'(1));
        chk("arst_hcnt", FW'(hit_cnt_o), '0);
        chk("arst_mcnt", FW'(miss_cnt_o), '0);
        q.delete();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sargantana_icache_checker_pipe.md
Name: sargantana_icache_checker_pipe

Overview:
Parametrised, registered successor to the instruction-cache tag checker.
- Compares the translated physical tag against N way tags and detects multi-way hits.
- Selects a FETCH_W chunk from the hitting line.
- Presents the result through a one-entry valid/ready output stage.
- Keeps saturating hit/miss counters.
- Sits between the tag/data SRAM read stage and the fetch-response logic.

Parameters:
N_WAY, 4, number of ways; power of two, ≥2
TAG_W, 20, physical tag width
LINE_W, 256, cache-line width in bits
FETCH_W, 128, fetch chunk width; LINE_W/FETCH_W = CHUNKS, a power of two ≥1
CNT_W, 32, width of the hit/miss performance counters

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_i  in  1  asynchronous, active-high reset
flush_i  in  1  drop the held response
req_valid_i  in  1  tags/data/index valid this cycle
req_ready_o  out  1  stage can accept a request
cline_tag_i  in  TAG_W  physical tag from the MMU
way_valid_bits_i  in  N_WAY  per-way valid bits
read_tags_i  in  N_WAY*TAG_W  tags read; way i at [i*TAG_W +: TAG_W]
data_rd_i  in  N_WAY*LINE_W  lines read; way i at [i*LINE_W +: LINE_W]
fetch_idx_i  in  max(1,log2(CHUNKS))  chunk index within the line; ignored when CHUNKS=1
rsp_valid_o  out  1  response held
rsp_ready_i  in  1  consumer takes the response
rsp_hit_o  out  1  at least one way hit
rsp_way_o  out  N_WAY  one-hot selected way; 0 on miss
rsp_multihit_o  out  1  more than one way hit (error)
rsp_data_o  out  FETCH_W  selected chunk; 0 on miss
cnt_clear_i  in  1  synchronous clear of both counters
hit_cnt_o  out  CNT_W  hit responses consumed
miss_cnt_o  out  CNT_W  miss responses consumed

Behaviour:
- Reset (asynchronous, rst_i=1): every register clears.
  - rsp_valid_o=0, rsp_hit_o=0, rsp_way_o=0, rsp_multihit_o=0, rsp_data_o=0, hit_cnt_o=0, miss_cnt_o=0.
  - req_ready_o=1 while in reset and after release.
- Combinational compare:
  - hit_vec[i] = (read_tags[i]==cline_tag_i) & way_valid_bits_i[i].
  - sel = lowest index with hit_vec set (priority encoder).
  - multihit = popcount(hit_vec) > 1.
  - chunk = data_rd[sel][fetch_idx*FETCH_W +: FETCH_W]; forced to 0 when no hit.
- Output stage, two states:
  - EMPTY: rsp_valid_o=0.
  - FULL: rsp_valid_o=1.
  - req_ready_o = EMPTY | rsp_ready_i (same-cycle pass-through of the free slot).
  - Accept = req_valid_i & req_ready_o & ~flush_i; on accept, register hit/way/multihit/data.
- Latency: exactly 1 cycle from accept to rsp_valid_o. Throughput: 1 per cycle while rsp_ready_i=1.
- Transitions:
  - EMPTY→FULL on accept.
  - FULL→EMPTY on rsp_ready_i with no accept.
  - FULL→FULL on rsp_ready_i with accept (back-to-back).
  - FULL holds when rsp_ready_i=0; all rsp_* outputs stay stable.
- flush_i has priority: next state EMPTY, no capture that cycle, any held response discarded and not counted; payload registers may keep stale values.
- Counters:
  - Update on the consume event rsp_valid_o & rsp_ready_i & ~flush_i.
  - hit_cnt_o increments if rsp_hit_o, else miss_cnt_o increments.
  - Both saturate at 2^CNT_W−1 (no wrap).
  - cnt_clear_i takes priority over an increment in the same cycle; result is 0.
- A multihit response is still reported as a hit with the lowest way; counted as a hit.
- Reset mid-operation discards the held response immediately, asynchronously.

Decomposition:
- Shared package sargantana_icache_pkg: default constants for N_WAY/TAG_W/LINE_W/FETCH_W, a typedef for the check-result struct {hit, way onehot, multihit}, and a chunk_idx width function.
- One sub-module: sargantana_icache_way_prio, a parametric lowest-index priority encoder with a multihit flag, generic in N_WAY.

Test Plan:
- Reset, then one request with tag 0x12345, way2 tag 0x12345 valid, fetch_idx=1 → next cycle rsp_valid=1, hit=1, way=0100, data=line2[255:128], hit_cnt=1 after consume.
- All valid bits 0 with matching tags → hit=0, way=0, data=0, miss_cnt increments by 1.
- Way1 and way3 both match → way=0010, multihit=1, data from way1.
- rsp_ready_i=0 for 5 cycles with req_valid_i held → req_ready_o=0, outputs stable.
  - Then rsp_ready_i=1 for 4 back-to-back requests → 4 responses in 4 cycles, no bubbles.
- flush_i asserted while FULL and with req_valid_i=1 → next cycle rsp_valid=0, counters unchanged.
- CNT_W=4: 17 hit consumes → hit_cnt=15. Clear with a simultaneous hit consume → 0.
